// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment scan driver.
//   NUM_DIGITS  - number of multiplexed digits
//   slot_t      - digit slot index
//   SEG_*       - segment patterns, bit order {g,f,e,d,c,b,a}, active-high
//   is_zero_digit - helper used by leading-zero suppression
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] slot_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // A digit counts as zero only for the exact value 0; invalid codes are nonzero.
  function automatic logic is_zero_digit(input logic [3:0] d);
    return (d == 4'd0);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to 7-segment decoder.
//   bcd - 4-bit digit value; 10..15 are shown as a dash
//   seg - segment pattern {g,f,e,d,c,b,a}, active-high
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digit lookup; any non-BCD code maps to the dash pattern.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a 4-digit common-segment
// 7-segment display. All four digits are captured into a shadow register once
// per frame so a frame never mixes old and new values; each digit slot starts
// with a short window where all digit enables are low to suppress ghosting.
//
// Parameters:
//   CLK_DIV      - clk cycles per digit slot (>= 2)
//   BLANK_CYCLES - cycles at slot start with digit_en low (< CLK_DIV)
// Ports:
//   clk         - system clock
//   reset_n     - asynchronous active-low reset
//   units..thousands - BCD digits 0..3 (units is the LSD)
//   digit_en    - one-hot digit select, active-high
//   seg         - segments {g,f,e,d,c,b,a}, active-high
//   frame_start - one-cycle pulse on each shadow load
// Build option:
//   SEG7_LEADING_ZERO_BLANK_EN - blank leading zero digits 3..1
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  output logic [3:0] digit_en,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_r;
  slot_t            slot_r;
  logic [15:0]      shadow_r;       // {d3,d2,d1,d0}
  logic [3:0]       digit_en_r;
  logic [6:0]       seg_r;
  logic             frame_start_r;

  logic             tick_s;
  logic             frame_end_s;
  logic [CNT_W-1:0] div_nxt_s;
  slot_t            slot_nxt_s;
  logic [15:0]      shadow_nxt_s;
  logic [3:0]       digit_nxt_s;
  logic [6:0]       seg_dec_s;
  logic             suppress_s;
  logic             blank_win_s;
  logic [3:0]       digit_en_nxt_s;
  logic [6:0]       seg_nxt_s;

  // Next-state of prescaler, slot counter and shadow; outputs are derived from
  // these so the registered outputs line up with the internal state.
  always_comb begin
    tick_s      = (div_cnt_r == DIV_MAX);
    frame_end_s = tick_s && (slot_r == 2'd3);
    if (tick_s) begin
      div_nxt_s  = {CNT_W{1'b0}};
      slot_nxt_s = slot_r + 2'd1;
    end else begin
      div_nxt_s  = div_cnt_r + CNT_W'(1);
      slot_nxt_s = slot_r;
    end
    if (frame_end_s) begin
      shadow_nxt_s = {thousands, hundreds, tens, units};
    end else begin
      shadow_nxt_s = shadow_r;
    end
  end

  // Pick the shadow digit belonging to the upcoming slot.
  always_comb begin
    digit_nxt_s = shadow_nxt_s[3:0];
    case (slot_nxt_s)
      2'd0:    digit_nxt_s = shadow_nxt_s[3:0];
      2'd1:    digit_nxt_s = shadow_nxt_s[7:4];
      2'd2:    digit_nxt_s = shadow_nxt_s[11:8];
      2'd3:    digit_nxt_s = shadow_nxt_s[15:12];
      default: digit_nxt_s = shadow_nxt_s[3:0];
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (digit_nxt_s),
    .seg (seg_dec_s)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic z1_s;
  logic z2_s;
  logic z3_s;

  // A digit is suppressed only when it and every more significant digit are zero.
  always_comb begin
    z1_s       = is_zero_digit(shadow_nxt_s[7:4]);
    z2_s       = is_zero_digit(shadow_nxt_s[11:8]);
    z3_s       = is_zero_digit(shadow_nxt_s[15:12]);
    suppress_s = 1'b0;
    case (slot_nxt_s)
      2'd3:    suppress_s = z3_s;
      2'd2:    suppress_s = z3_s & z2_s;
      2'd1:    suppress_s = z3_s & z2_s & z1_s;
      default: suppress_s = 1'b0;
    endcase
  end
`else
  // All digits, including zeros, are always shown.
  always_comb begin
    suppress_s = 1'b0;
  end
`endif

  // Blank window at the start of each slot (absent when BLANK_CYCLES is 0).
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign blank_win_s = 1'b0;
  end else begin : g_blank
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
    assign blank_win_s = (div_nxt_s < BLANK_LIM);
  end

  // Output values for the next cycle; seg stays valid through the blank window.
  always_comb begin
    if (blank_win_s) begin
      digit_en_nxt_s = 4'b0000;
    end else begin
      digit_en_nxt_s = 4'b0001 << slot_nxt_s;
    end
    if (suppress_s) begin
      seg_nxt_s = SEG_OFF;
    end else begin
      seg_nxt_s = seg_dec_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r     <= {CNT_W{1'b0}};
      slot_r        <= 2'd0;
      shadow_r      <= 16'h0000;
      digit_en_r    <= 4'b0000;
      seg_r         <= SEG_OFF;
      frame_start_r <= 1'b0;
    end else begin
      div_cnt_r     <= div_nxt_s;
      slot_r        <= slot_nxt_s;
      shadow_r      <= shadow_nxt_s;
      digit_en_r    <= digit_en_nxt_s;
      seg_r         <= seg_nxt_s;
      frame_start_r <= frame_end_s;
    end
  end

  assign digit_en    = digit_en_r;
  assign seg         = seg_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: self-checking bench for seg7_scan_driver with
// CLK_DIV=4, BLANK_CYCLES=1. A cycle-count reference model (edges since reset
// release, frame/slot/position by division) predicts every output each cycle;
// a vector table and hand sequences check specific frames and corner cases.
module tb_seg7_scan_driver;

  localparam int CLK_DIV = 4;
  localparam int BLANK   = 1;
  localparam int FRAME   = 4 * CLK_DIV;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZB = 7'h00;
`else
  localparam logic [6:0] ZB = 7'h3F;
`endif

  logic       clk;
  logic       reset_n;
  logic [3:0] units, tens, hundreds, thousands;
  logic [3:0] digit_en;
  logic [6:0] seg;
  logic       frame_start;

  seg7_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .units       (units),
    .tens        (tens),
    .hundreds    (hundreds),
    .thousands   (thousands),
    .digit_en    (digit_en),
    .seg         (seg),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;              // clock edges since reset release
  logic [3:0] dig[4];     // model's captured digits
  logic [6:0] lut[16];

  typedef struct packed {
    logic [15:0] digits;  // {thousands,hundreds,tens,units}
    logic [27:0] segs;    // {slot3,slot2,slot1,slot0}
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  function automatic logic [6:0] model_seg(input int s);
    logic blank;
    blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (s > 0) begin
      blank = 1'b1;
      for (int j = s; j < 4; j++) if (dig[j] != 4'd0) blank = 1'b0;
    end
`endif
    return blank ? 7'h00 : lut[dig[s]];
  endfunction

  task automatic model_check();
    int pos, slot;
    logic [3:0] en;
    pos  = n % CLK_DIV;
    slot = (n / CLK_DIV) % 4;
    en   = (pos < BLANK) ? 4'b0000 : (4'b0001 << slot);
    chk("model_digit_en", {28'd0, digit_en}, {28'd0, en});
    chk("model_seg", {25'd0, seg}, {25'd0, model_seg(slot)});
    chk("model_frame_start", {31'd0, frame_start}, {31'd0, (n % FRAME == 0)});
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    if (n % FRAME == 0) begin
      dig[0] = units; dig[1] = tens; dig[2] = hundreds; dig[3] = thousands;
    end
    #1;
    model_check();
  endtask

  task automatic step_to_frame();
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (n % FRAME == 0) break;
    end
  endtask

  task automatic set_in(input logic [15:0] d);
    {thousands, hundreds, tens, units} = d;
  endtask

  // Run one frame (assumed aligned) and compare the mid-slot seg with exp.
  task automatic check_frame(input string name, input logic [27:0] exp);
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (n % CLK_DIV == 2) chk(name, {25'd0, seg}, {25'd0, exp[((n / CLK_DIV) % 4) * 7 +: 7]});
    end
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_en"}, {28'd0, digit_en}, 32'd0);
    chk({name, "_seg"}, {25'd0, seg}, 32'd0);
    chk({name, "_fs"}, {31'd0, frame_start}, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) dig[i] = 4'd0;
  endtask

  initial begin
    int first_fs;
    lut[0] = 7'h3F; lut[1] = 7'h06; lut[2] = 7'h5B; lut[3] = 7'h4F;
    lut[4] = 7'h66; lut[5] = 7'h6D; lut[6] = 7'h7D; lut[7] = 7'h07;
    lut[8] = 7'h7F; lut[9] = 7'h6F;
    for (int i = 10; i < 16; i++) lut[i] = 7'h40;

    tbl[0] = '{16'h1234, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    tbl[1] = '{16'h9875, {7'h6F, 7'h7F, 7'h07, 7'h6D}};
    tbl[2] = '{16'h000A, {ZB,    ZB,    ZB,    7'h40}};
    tbl[3] = '{16'h0007, {ZB,    ZB,    ZB,    7'h07}};
    tbl[4] = '{16'h0000, {ZB,    ZB,    ZB,    7'h3F}};
    tbl[5] = '{16'hF000, {7'h40, 7'h3F, 7'h3F, 7'h3F}};
    tbl[6] = '{16'h0B01, {ZB,    7'h40, 7'h3F, 7'h06}};
    tbl[7] = '{16'h602C, {7'h7D, 7'h3F, 7'h5B, 7'h40}};

    for (int i = 0; i < 4; i++) dig[i] = 4'd0;
    reset_n = 1'b0;
    set_in(16'h1234);
    #3;
    check_zero_outputs("reset_no_clk");
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_held");
    release_reset();

    // First frame shows zeros, frame_start on edge 16.
    first_fs = -1;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (frame_start && first_fs < 0) first_fs = n;
    end
    chk("first_frame_start_cycle", first_fs, 32'd16);
    check_frame("second_frame_1234", {7'h06, 7'h5B, 7'h4F, 7'h66});

    // Vector table.
    for (int v = 0; v < 8; v++) begin
      set_in(tbl[v].digits);
      step_to_frame();
      check_frame("tbl_seg", tbl[v].segs);
    end

    // Anti-tearing: inputs change in slot 1, rest of frame keeps old digits.
    set_in(16'h1234);
    step_to_frame();
    for (int k = 0; k < 6; k++) step();
    set_in(16'h5678);
    for (int k = 6; k < FRAME; k++) begin
      step();
      if (n % CLK_DIV == 2) chk("tear_old_digits", {25'd0, seg},
                                {25'd0, ((n / CLK_DIV) % 4 == 2) ? 7'h5B : 7'h06});
    end
    check_frame("tear_new_frame", {7'h6D, 7'h7D, 7'h07, 7'h7F});

    // Asynchronous reset during slot 2, between clock edges.
    set_in(16'h4321);
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (n % FRAME == 9) break;
    end
    #2 reset_n = 1'b0;
    #1;
    check_zero_outputs("midframe_reset");
    repeat (2) @(posedge clk);
    release_reset();
    step();
    chk("resume_slot0_en", {28'd0, digit_en}, 32'd1);
    chk("resume_shadow0_seg", {25'd0, seg}, 32'h3F);
    for (int k = 1; k < FRAME; k++) step();

    // Randomized input activity against the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       units     = 4'($urandom_range(0, 15));
          1:       tens      = 4'($urandom_range(0, 15));
          2:       hundreds  = 4'($urandom_range(0, 15));
          default: thousands = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 15) == 0) begin
        units = 4'd0; tens = 4'd0; hundreds = 4'd0;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
